irq_csr_ctrl: RTL and testbench

IRQ_CSR_CTRL -- requirements
Module: irq_csr_ctrl

---
 rtl/irq_csr_ctrl_pkg.sv | 41 ++++
 rtl/irq_csr_ctrl_csr_file.sv | 85 ++++++++
 rtl/irq_csr_ctrl.sv | 77 +++++++
 tb/tb_irq_csr_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_csr_ctrl_pkg.sv
// Shared definitions for the interrupt CSR controller: CSR map, CSR op
// encodings, FSM state type and the read-modify-write helper.
package irq_csr_ctrl_pkg;

  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  function automatic logic csr_op_writes(input logic [2:0] op);
    return (op[1:0] != 2'b00);
  endfunction

  // The immediate variants carry an already-extended operand on wdata.
  function automatic logic [31:0] csr_op_apply(input logic [2:0]  op,
                                               input logic [31:0] old,
                                               input logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      F3_CSRRW, F3_CSRRWI: res = wdata;
      F3_CSRRS, F3_CSRRSI: res = old | wdata;
      F3_CSRRC, F3_CSRRCI: res = old & ~wdata;
      default:             res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/irq_csr_ctrl_csr_file.sv
// Machine-mode interrupt CSR storage with combinational read mux and
// read-modify-write update; trap entry overrides software writes to mepc/mcause.
module csr_file
  import irq_csr_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [2:0]  op_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        trap_load_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  output logic [31:0] rdata_o,
  output logic [15:0] mask_o,
  output logic [31:0] mtvec_base_o,
  output logic [31:0] mepc_o
);

  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] new_val;
  logic        do_wr;

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CSR_MIE:      rdata_o = mie_q;
      CSR_MTVEC:    rdata_o = mtvec_q;
      CSR_MSCRATCH: rdata_o = mscratch_q;
      CSR_MEPC:     rdata_o = mepc_q;
      CSR_MCAUSE:   rdata_o = mcause_q;
      default:      rdata_o = '0;
    endcase
  end

  always_comb begin
    new_val    = csr_op_apply(op_i, rdata_o, wdata_i);
    do_wr      = wr_en_i && csr_op_writes(op_i);
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (do_wr) begin
      case (addr_i)
        CSR_MIE:      mie_d      = new_val;
        CSR_MTVEC:    mtvec_d    = new_val;
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = new_val;
        CSR_MCAUSE:   mcause_d   = new_val;
        default:      ;
      endcase
    end
    if (trap_load_i) begin
      mepc_d   = trap_pc_i;
      mcause_d = trap_cause_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign mask_o       = mie_q[19:4];
  assign mtvec_base_o = {mtvec_q[31:2], 2'b00};
  assign mepc_o       = mepc_q;

endmodule

// File: rtl/irq_csr_ctrl.sv
// Single-level interrupt controller: trap entry/return FSM and PC redirect
// in front of the machine-mode interrupt CSRs.
//   state   | meaning
//   ST_IDLE | no trap active, chain may grant a new interrupt
//   ST_TRAP | handler running, further interrupts ignored until mret
module irq_csr_ctrl
  import irq_csr_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_i,
  input  logic [31:0] irq_cause_i,
  output logic        ready_o,
  output logic        irq_ret_o,
  output logic [15:0] mask_o,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        mret_i,
  input  logic        csr_en_i,
  input  logic [2:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        pc_redirect_o,
  output logic [31:0] trap_pc_o
);

  state_e      state_q, state_d;
  logic        trap_enter;
  logic        trap_return;
  logic        idle_mret;
  logic [31:0] mtvec_base;
  logic [31:0] mepc;

  // Events are suppressed during reset so a trap is abandoned silently.
  always_comb begin
    trap_enter  = !rst_i && (state_q == ST_IDLE) && irq_i && !stall_i;
    trap_return = !rst_i && (state_q == ST_TRAP) && mret_i && !stall_i;
    idle_mret   = !rst_i && (state_q == ST_IDLE) && mret_i && !stall_i && !trap_enter;
    state_d     = state_q;
    if (trap_enter)  state_d = ST_TRAP;
    if (trap_return) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // mepc here is the pre-write value, so a same-cycle CSR write cannot move the return target.
  always_comb begin
    pc_redirect_o = trap_enter || trap_return || idle_mret;
    irq_ret_o     = trap_return;
    trap_pc_o     = '0;
    if (trap_enter)                    trap_pc_o = mtvec_base;
    else if (trap_return || idle_mret) trap_pc_o = mepc;
  end

  assign ready_o = (state_q == ST_IDLE) && !stall_i;

  csr_file u_csr_file (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_en_i      (csr_en_i && !stall_i),
    .op_i         (csr_op_i),
    .addr_i       (csr_addr_i),
    .wdata_i      (csr_wdata_i),
    .trap_load_i  (trap_enter),
    .trap_pc_i    (pc_i),
    .trap_cause_i (irq_cause_i),
    .rdata_o      (csr_rdata_o),
    .mask_o       (mask_o),
    .mtvec_base_o (mtvec_base),
    .mepc_o       (mepc)
  );

endmodule

// File: tb/tb_irq_csr_ctrl.sv
// Bench for irq_csr_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_irq_csr_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i, irq_i, stall_i, mret_i, csr_en_i;
  logic [31:0] irq_cause_i, pc_i, csr_wdata_i;
  logic [2:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic        ready_o, irq_ret_o, pc_redirect_o;
  logic [15:0] mask_o;
  logic [31:0] csr_rdata_o, trap_pc_o;

  int checks = 0;
  int failures = 0;

  // model: CSRs as an array indexed 0..4 = mie, mtvec, mscratch, mepc, mcause
  logic [31:0] m_csr [5];
  bit          m_trap;

  always #5 clk_i = ~clk_i;

  irq_csr_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i), .irq_cause_i(irq_cause_i),
    .ready_o(ready_o), .irq_ret_o(irq_ret_o), .mask_o(mask_o),
    .stall_i(stall_i), .pc_i(pc_i), .mret_i(mret_i),
    .csr_en_i(csr_en_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .pc_redirect_o(pc_redirect_o), .trap_pc_o(trap_pc_o)
  );

  function automatic int csr_index(input logic [11:0] a);
    case (a)
      12'h304: return 0;
      12'h305: return 1;
      12'h340: return 2;
      12'h341: return 3;
      12'h342: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int          idx;
    bit          enter, ret, imret;
    logic [31:0] exp_pc, exp_rd;
    enter = !rst_i && !m_trap && irq_i && !stall_i;
    ret   = !rst_i && m_trap && mret_i && !stall_i;
    imret = !rst_i && !m_trap && mret_i && !stall_i && !enter;
    exp_pc = 32'h0;
    if (enter) exp_pc = m_csr[1] & 32'hFFFF_FFFC;
    else if (ret || imret) exp_pc = m_csr[3];
    idx = csr_index(csr_addr_i);
    exp_rd = (idx < 0) ? 32'h0 : m_csr[idx];
    check("ready",    {31'b0, ready_o},       {31'b0, !m_trap && !stall_i});
    check("redirect", {31'b0, pc_redirect_o}, {31'b0, enter || ret || imret});
    check("irq_ret",  {31'b0, irq_ret_o},     {31'b0, ret});
    check("trap_pc",  trap_pc_o, exp_pc);
    check("rdata",    csr_rdata_o, exp_rd);
    check("mask",     {16'b0, mask_o}, {16'b0, m_csr[0][19:4]});
  endtask

  task automatic model_update();
    int          idx;
    bit          enter, ret;
    logic [31:0] old;
    if (rst_i) begin
      for (int i = 0; i < 5; i++) m_csr[i] = 32'h0;
      m_trap = 0;
      return;
    end
    enter = !m_trap && irq_i && !stall_i;
    ret   = m_trap && mret_i && !stall_i;
    idx   = csr_index(csr_addr_i);
    if (csr_en_i && !stall_i && idx >= 0 && !(enter && idx >= 3)) begin
      old = m_csr[idx];
      case (csr_op_i[1:0])
        2'b01: m_csr[idx] = csr_wdata_i;
        2'b10: m_csr[idx] = old | csr_wdata_i;
        2'b11: m_csr[idx] = old & ~csr_wdata_i;
        default: ;
      endcase
    end
    if (enter) begin
      m_csr[3] = pc_i;
      m_csr[4] = irq_cause_i;
      m_trap   = 1;
    end
    if (ret) m_trap = 0;
  endtask

  // Called just after a negedge with inputs already applied.
  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic advance();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    rst_i = 0; irq_i = 0; stall_i = 0; mret_i = 0; csr_en_i = 0;
    irq_cause_i = 0; pc_i = 0; csr_wdata_i = 0; csr_op_i = 0; csr_addr_i = 0;
  endtask

  initial begin
    int          r;
    logic [11:0] addr_pool [6];
    addr_pool = '{12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h000};
    for (int i = 0; i < 5; i++) m_csr[i] = 32'hDEAD_BEEF;
    m_trap = 1;
    idle_inputs();
    @(negedge clk_i);
    rst_i = 1;
    advance();
    rst_i = 0;
    settle();
    check("rst_mask", {16'b0, mask_o}, 32'h0);
    check("rst_ready", {31'b0, ready_o}, 32'h1);
    advance();

    // mtvec write + readback, mie set -> mask
    csr_en_i = 1; csr_op_i = 3'b001; csr_addr_i = 12'h305; csr_wdata_i = 32'h100;
    step();
    csr_en_i = 0;
    settle();
    check("mtvec_rd", csr_rdata_o, 32'h0000_0100);
    advance();
    csr_en_i = 1; csr_op_i = 3'b010; csr_addr_i = 12'h304; csr_wdata_i = 32'h30;
    step();
    csr_en_i = 0;
    settle();
    check("mask_set", {16'b0, mask_o}, 32'h0003);
    advance();

    // trap entry
    irq_i = 1; irq_cause_i = 32'h8000_0010; pc_i = 32'h40;
    settle();
    check("entry_redir", {31'b0, pc_redirect_o}, 32'h1);
    check("entry_pc", trap_pc_o, 32'h100);
    advance();
    irq_i = 0; csr_addr_i = 12'h341;
    settle();
    check("mepc", csr_rdata_o, 32'h40);
    check("trap_ready", {31'b0, ready_o}, 32'h0);
    advance();
    csr_addr_i = 12'h342;
    settle();
    check("mcause", csr_rdata_o, 32'h8000_0010);
    advance();

    // irq ignored while in TRAP, then mret
    irq_i = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("nest_redir", {31'b0, pc_redirect_o}, 32'h0);
      advance();
    end
    irq_i = 0; mret_i = 1;
    settle();
    check("ret_redir", {31'b0, pc_redirect_o}, 32'h1);
    check("ret_pc", trap_pc_o, 32'h40);
    check("ret_pulse", {31'b0, irq_ret_o}, 32'h1);
    advance();
    mret_i = 0; irq_i = 1; pc_i = 32'h44;
    settle();
    check("post_ready", {31'b0, ready_o}, 32'h1);
    check("post_pulse", {31'b0, irq_ret_o}, 32'h0);
    check("regrant", {31'b0, pc_redirect_o}, 32'h1);
    advance();
    irq_i = 0; mret_i = 1;
    step();
    mret_i = 0;

    // stall defers entry
    stall_i = 1; irq_i = 1; pc_i = 32'h60;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_redir", {31'b0, pc_redirect_o}, 32'h0);
      advance();
    end
    stall_i = 0;
    settle();
    check("unstall_redir", {31'b0, pc_redirect_o}, 32'h1);
    advance();
    irq_i = 0; mret_i = 1;
    step();
    mret_i = 0;

    // entry beats same-cycle mepc write; reset in TRAP
    irq_i = 1; pc_i = 32'h80; csr_en_i = 1; csr_op_i = 3'b001;
    csr_addr_i = 12'h341; csr_wdata_i = 32'hFFFF;
    step();
    irq_i = 0; csr_en_i = 0;
    settle();
    check("mepc_prio", csr_rdata_o, 32'h80);
    advance();
    rst_i = 1; mret_i = 1;
    settle();
    check("rst_no_pulse", {31'b0, irq_ret_o}, 32'h0);
    advance();
    rst_i = 0; mret_i = 0; csr_addr_i = 12'h304;
    settle();
    check("rst2_mask", {16'b0, mask_o}, 32'h0);
    check("rst2_ready", {31'b0, ready_o}, 32'h1);
    advance();
    csr_addr_i = 12'h341;
    settle();
    check("rst2_mepc", csr_rdata_o, 32'h0);
    advance();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst_i       = ($urandom_range(0, 99) == 0);
      irq_i       = ($urandom_range(0, 3) == 0);
      stall_i     = ($urandom_range(0, 3) == 0);
      mret_i      = ($urandom_range(0, 5) == 0);
      csr_en_i    = ($urandom_range(0, 2) == 0);
      csr_op_i    = 3'($urandom_range(0, 7));
      r           = $urandom_range(0, 5);
      csr_addr_i  = (r == 5) ? 12'($urandom) : addr_pool[r];
      csr_wdata_i = $urandom;
      irq_cause_i = $urandom;
      pc_i        = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
